// File: rtl/vga_timing_pkg.sv
// Shared timing types, standard video modes and helpers for the VGA timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } video_mode_t;

    localparam video_mode_t VGA_640x480_60 = '{
        h: '{active: 640, front: 16, sync: 96,  back: 48},
        v: '{active: 480, front: 10, sync: 2,   back: 33}
    };

    localparam video_mode_t VGA_800x600_60 = '{
        h: '{active: 800, front: 40, sync: 128, back: 88},
        v: '{active: 600, front: 1,  sync: 4,   back: 23}
    };

    function automatic int unsigned total(axis_timing_t t);
        return t.active + t.front + t.sync + t.back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Single-axis timing counter: sync -> back porch -> active -> front porch, then wrap.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FRONT  = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BACK   = 48,
    parameter int unsigned CW     = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          sync,
    output logic          active,
    output logic [CW-1:0] coord
);

    localparam axis_timing_t T     = '{active: ACTIVE, front: FRONT, sync: SYNC, back: BACK};
    localparam int unsigned  TOTAL = total(T);
    localparam int unsigned  START = SYNC + BACK;

    if (ACTIVE == 0 || FRONT == 0 || SYNC == 0 || BACK == 0) begin : g_zero_param
        $fatal(1, "vga_axis_counter: timing parameters must all be non-zero");
    end
    if (longint'(TOTAL) > (longint'(1) << CW) - 1) begin : g_width_param
        $fatal(1, "vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, CW);
    end

    assign wrap   = (count == CW'(TOTAL - 1));
    assign sync   = (count < CW'(SYNC));
    assign active = (count >= CW'(START)) && (count < CW'(START + ACTIVE));
    assign coord  = active ? count - CW'(START) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator with registered sync, display-enable, coordinates and strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_640x480_60.h.active,
    parameter int unsigned H_FRONT  = VGA_640x480_60.h.front,
    parameter int unsigned H_SYNC   = VGA_640x480_60.h.sync,
    parameter int unsigned H_BACK   = VGA_640x480_60.h.back,
    parameter int unsigned V_ACTIVE = VGA_640x480_60.v.active,
    parameter int unsigned V_FRONT  = VGA_640x480_60.v.front,
    parameter int unsigned V_SYNC   = VGA_640x480_60.v.sync,
    parameter int unsigned V_BACK   = VGA_640x480_60.v.back,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          restart,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start
);

    localparam int unsigned VBLANK_LINE = V_SYNC + V_BACK + V_ACTIVE;

    logic [CW-1:0] h_cnt, v_cnt, h_coord, v_coord;
    logic          h_wrap, h_sync, h_active;
    logic          v_sync, v_active;
    logic          v_wrap_unused;  // end-of-frame carry has no consumer here
    logic          clear;

    assign clear = en && restart;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CW(CW)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .inc    (en),
        .clear  (clear),
        .count  (h_cnt),
        .wrap   (h_wrap),
        .sync   (h_sync),
        .active (h_active),
        .coord  (h_coord)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CW(CW)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .inc    (en && h_wrap),
        .clear  (clear),
        .count  (v_cnt),
        .wrap   (v_wrap_unused),
        .sync   (v_sync),
        .active (v_active),
        .coord  (v_coord)
    );

    // Outputs describe the pre-edge counter position, so they stay aligned with (h_cnt, v_cnt).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs           <= !HS_POL;
            vs           <= !VS_POL;
            de           <= 1'b0;
            x            <= '0;
            y            <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else if (en) begin
            hs           <= h_sync ? HS_POL : !HS_POL;
            vs           <= v_sync ? VS_POL : !VS_POL;
            de           <= h_active && v_active;
            x            <= (h_active && v_active) ? h_coord : '0;
            y            <= v_coord;
            line_start   <= (h_cnt == '0);
            frame_start  <= (h_cnt == '0) && (v_cnt == '0);
            vblank_start <= (h_cnt == '0) && (v_cnt == CW'(VBLANK_LINE));
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a tiny timing config plus full-size horizontal/vertical instances.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset, en, restart, en_big;
    always #5 clk = ~clk;

    // Tiny config: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), CW=4.
    logic       hs, vs, de, ls, fs, vb;
    logic [3:0] x, y;
    logic [13:0] obs;
    assign obs = {hs, vs, de, x, y, ls, fs, vb};

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(4)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .restart(restart),
        .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
        .line_start(ls), .frame_start(fs), .vblank_start(vb)
    );

    // Default 640x480 instance.
    logic        d_hs, d_vs, d_de, d_ls, d_fs, d_vb;
    logic [10:0] d_x, d_y;
    vga_timing_gen dut_640 (
        .clk(clk), .reset(reset), .en(en_big), .restart(1'b0),
        .hs(d_hs), .vs(d_vs), .de(d_de), .x(d_x), .y(d_y),
        .line_start(d_ls), .frame_start(d_fs), .vblank_start(d_vb)
    );

    // Default vertical timing with a 4-pixel line so a full 525-line frame is short.
    logic        v_hs, v_vs, v_de, v_ls, v_fs, v_vb;
    logic [10:0] v_x, v_y;
    vga_timing_gen #(
        .H_ACTIVE(1), .H_FRONT(1), .H_SYNC(1), .H_BACK(1)
    ) dut_vert (
        .clk(clk), .reset(reset), .en(en_big), .restart(1'b0),
        .hs(v_hs), .vs(v_vs), .de(v_de), .x(v_x), .y(v_y),
        .line_start(v_ls), .frame_start(v_fs), .vblank_start(v_vb)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int hm = 0;
    int vm = 0;
    logic [13:0] last;

    localparam logic [13:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {hs,vs,de,x,y,line_start,frame_start,vblank_start} for counters (h,v), tiny config.
    function automatic logic [13:0] model(int h, int v);
        logic ha, va, d;
        logic [3:0] xe, ye;
        ha = (h >= 3) && (h < 7);
        va = (v >= 2) && (v < 5);
        d  = ha && va;
        xe = d  ? 4'(h - 3) : 4'd0;
        ye = va ? 4'(v - 2) : 4'd0;
        return {h >= 2, v >= 1, d, xe, ye, h == 0, (h == 0) && (v == 0), (h == 0) && (v == 5)};
    endfunction

    task automatic advance();
        if (hm == 7) begin
            hm = 0;
            vm = (vm == 5) ? 0 : vm + 1;
        end else begin
            hm++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One enabled edge on the tiny DUT, compared against the model.
    task automatic step_en(input string tag);
        en = 1'b1;
        tick();
        last = model(hm, vm);
        check(tag, 32'(obs), 32'(last));
        advance();
    endtask

    initial begin
        int fs_prev, fs_gap, de_cnt, hs_low, done;
        int d_de_cnt, d_xmax, d_ls1, d_ls2, v_de_cnt, v_ymax, v_ls_cnt, v_fs1, v_fs2;

        reset = 1'b1; en = 1'b0; restart = 1'b0; en_big = 1'b0;
        repeat (3) tick();
        check("reset_vec", 32'(obs), 32'(RESET_VEC));
        reset = 1'b0;
        tick();
        check("idle_hold", 32'(obs), 32'(RESET_VEC));

        // Test 1/2: continuous enable for two frames, model compared every cycle.
        fs_prev = -1; fs_gap = 0; de_cnt = 0; hs_low = 0;
        for (int i = 0; i < 96; i++) begin
            step_en("run");
            if (fs) begin
                if (fs_prev >= 0) fs_gap = i - fs_prev;
                fs_prev = i;
            end
            if (i < 48 && de) de_cnt++;
            if (i < 8 && !hs) hs_low++;
        end
        check("frame_period", 32'(fs_gap), 32'd48);
        check("de_per_frame", 32'(de_cnt), 32'd12);
        check("hs_low_per_line", 32'(hs_low), 32'd2);

        // Test 3: en toggling; outputs hold and strobes drop while en=0.
        fs_prev = -1; fs_gap = 0;
        for (int i = 0; i < 98; i++) begin
            if (i % 2 == 0) begin
                step_en("toggle_on");
            end else begin
                en = 1'b0;
                tick();
                last = last & ~14'b111;
                check("toggle_hold", 32'(obs), 32'(last));
            end
            if (fs) begin
                if (fs_prev >= 0) fs_gap = i - fs_prev;
                fs_prev = i;
            end
        end
        check("toggle_frame_period", 32'(fs_gap), 32'd96);

        // restart with en=0 is ignored
        while (!(hm == 5 && vm == 3) && n_chk < 2000) step_en("to_restart");
        en = 1'b0; restart = 1'b1;
        tick();
        check("restart_no_en", 32'(obs), 32'(last & ~14'b111));
        restart = 1'b0;
        step_en("restart_ignored");

        // Test 4: restart at h=5,v=3 with en=1.
        while (!(hm == 5 && vm == 3) && n_chk < 2000) step_en("to_restart2");
        restart = 1'b1;
        step_en("restart_edge");
        hm = 0; vm = 0;
        restart = 1'b0;
        en = 1'b1;
        tick();
        check("restart_fs", 32'(fs), 32'd1);
        check("restart_ls", 32'(ls), 32'd1);
        check("restart_hs", 32'(hs), 32'd0);
        check("restart_vs", 32'(vs), 32'd0);
        check("restart_de", 32'(de), 32'd0);
        advance();

        // Test 5: async reset while de=1 and x=2.
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            step_en("to_mid_active");
            if (last[11] && last[10:7] == 4'd2) done = 1;
        end
        check("reached_x2", 32'(done), 32'd1);
        #2 reset = 1'b1;
        #1 check("async_reset", 32'(obs), 32'(RESET_VEC));
        tick();
        check("reset_held", 32'(obs), 32'(RESET_VEC));
        reset = 1'b0;
        hm = 0; vm = 0;
        step_en("post_reset_first");
        check("post_reset_fs", 32'(fs), 32'd1);
        for (int i = 1; i < 48; i++) step_en("post_reset_run");
        en = 1'b0;

        // Test 6: default 640x480 horizontal and default vertical timing.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        en_big = 1'b1;
        d_de_cnt = 0; d_xmax = 0; d_ls1 = 0; d_ls2 = 0;
        v_de_cnt = 0; v_ymax = 0; v_ls_cnt = 0; v_fs1 = 0; v_fs2 = 0;
        for (int i = 1; i <= 29600; i++) begin
            tick();
            if (d_de) d_de_cnt++;
            if (int'(d_x) > d_xmax) d_xmax = int'(d_x);
            if (d_ls) begin
                if (d_ls1 == 0) d_ls1 = i;
                else if (d_ls2 == 0) d_ls2 = i;
            end
            if (i <= 2100) begin
                if (v_de) v_de_cnt++;
                if (v_ls) v_ls_cnt++;
                if (int'(v_y) > v_ymax) v_ymax = int'(v_y);
            end
            if (v_fs) begin
                if (v_fs1 == 0) v_fs1 = i;
                else if (v_fs2 == 0) v_fs2 = i;
            end
        end
        en_big = 1'b0;
        check("d640_line_period", 32'(d_ls2 - d_ls1), 32'd800);
        check("d640_de_37_lines", 32'(d_de_cnt), 32'd1280);
        check("d640_x_max", 32'(d_xmax), 32'd639);
        check("vert_lines_per_frame", 32'(v_ls_cnt), 32'd525);
        check("vert_frame_period", 32'(v_fs2 - v_fs1), 32'd2100);
        check("vert_de_per_frame", 32'(v_de_cnt), 32'd480);
        check("vert_y_max", 32'(v_ymax), 32'd479);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
